bus_target: RTL and testbench

Bus-side responder for the shared tristate data bus that the team's `drvr` cells drive. It decodes the address with the same XNOR/AND equality scheme as `equal`, captures write data into a small register file, and drives read data back onto the bus through tristate drivers. It acknowledges with a four-phase handshake. It is the receiving and responding end of any initiator built from the existing cell library.

---
 rtl/bus_target.sv | 107 ++++++++++
 tb/tb_bus_target.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_target.sv
// Register-file responder on a shared tristate bus with a four-phase req/ack handshake.
// Optional macro TGT_TIMEOUT_EN bounds HOLD to 16 ack cycles and pulses err on expiry.
module bus_target #(
    parameter int unsigned   AW   = 4,
    parameter int unsigned   DW   = 8,
    parameter logic [AW-1:0] BASE = 4'h8
) (
    input  logic          c,
    input  logic          r,
    input  logic          req,
    input  logic          wr,
    input  logic [AW-1:0] adr,
    inout  wire  [DW-1:0] data,
    output logic          ack,
    output logic          oe,
    output logic          err
);

    typedef enum logic [1:0] {StIdle, StAct, StHold, StWait} state_e;

    state_e        state;
    logic [DW-1:0] regs [4];
    logic [1:0]    idx;
    logic          wr_q;
    logic          hit;
`ifdef TGT_TIMEOUT_EN
    logic [3:0]    cnt;
`endif

    // Bitwise XNOR then AND-reduce: equality on the block-select bits.
    assign hit  = &(adr[AW-1:2] ~^ BASE[AW-1:2]);
    assign data = oe ? regs[idx] : {DW{1'bz}};

    always_ff @(posedge c or posedge r) begin
        if (r) begin
            state <= StIdle;
            idx   <= 2'd0;
            wr_q  <= 1'b0;
            ack   <= 1'b0;
            oe    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
`ifdef TGT_TIMEOUT_EN
            cnt   <= 4'd0;
            err   <= 1'b0;
`endif
        end else begin
`ifdef TGT_TIMEOUT_EN
            err <= 1'b0;
`endif
            case (state)
                StIdle: begin
                    if (req && hit) begin
                        state <= StAct;
                        idx   <= adr[1:0];
                        wr_q  <= wr;
                        oe    <= ~wr;
                    end
                end
                StAct: begin
                    if (req) begin
                        state <= StHold;
                        ack   <= 1'b1;
                        if (wr_q) begin
                            regs[idx] <= data;
                        end
`ifdef TGT_TIMEOUT_EN
                        cnt <= 4'd0;
`endif
                    end else begin
                        state <= StIdle;
                        oe    <= 1'b0;
                    end
                end
                StHold: begin
                    if (!req) begin
                        state <= StIdle;
                        ack   <= 1'b0;
                        oe    <= 1'b0;
                    end
`ifdef TGT_TIMEOUT_EN
                    else if (cnt == 4'hF) begin
                        state <= StWait;
                        ack   <= 1'b0;
                        oe    <= 1'b0;
                        err   <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
`endif
                end
                StWait: begin
                    if (!req) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifndef TGT_TIMEOUT_EN
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_target.sv
// Directed bench for bus_target: table of whole accesses plus hand sequences for
// miss, abort, reset mid-access, latched-control and long-hold behaviour.
module tb_bus_target;

    logic       c = 1'b0;
    logic       r = 1'b1;
    logic       req = 1'b0;
    logic       wr = 1'b0;
    logic [3:0] adr = 4'h0;
    logic [7:0] drv = 8'h00;
    logic       drv_en = 1'b0;
    wire  [7:0] data;
    logic       ack;
    logic       oe;
    logic       err;

    int n_vec = 0;
    int n_fail = 0;

    typedef struct packed {
        logic       w;
        logic [3:0] a;
        logic [7:0] wd;
        logic       hit;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [12];

    assign data = drv_en ? drv : 8'hzz;

    bus_target #(
        .AW  (4),
        .DW  (8),
        .BASE(4'h8)
    ) dut (
        .c   (c),
        .r   (r),
        .req (req),
        .wr  (wr),
        .adr (adr),
        .data(data),
        .ack (ack),
        .oe  (oe),
        .err (err)
    );

    always #5 c = ~c;

    task automatic check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge c);
        #1;
    endtask

    // One complete four-phase access; starts and ends with the target idle.
    task automatic access(input vec_t v);
        logic rd_hit;
        rd_hit = v.hit && !v.w;
        req = 1'b1; wr = v.w; adr = v.a; drv = v.wd; drv_en = v.w;
        tick();
        check1("oe_act", oe, rd_hit);
        check1("ack_act", ack, 1'b0);
        if (rd_hit) check8("rd_act", data, v.exp);
        tick();
        check1("ack_hold", ack, v.hit);
        check1("oe_hold", oe, rd_hit);
        check1("err_hold", err, 1'b0);
        if (rd_hit) check8("rd_hold", data, v.exp);
        req = 1'b0; wr = 1'b0; drv_en = 1'b0;
        tick();
        check1("ack_rel", ack, 1'b0);
        check1("oe_rel", oe, 1'b0);
        tick();
    endtask

    initial begin
        //           w     adr    wdata  hit   exp
        vecs[0]  = '{1'b0, 4'h9, 8'h00, 1'b1, 8'h00};
        vecs[1]  = '{1'b1, 4'hA, 8'hA5, 1'b1, 8'h00};
        vecs[2]  = '{1'b0, 4'hA, 8'h00, 1'b1, 8'hA5};
        vecs[3]  = '{1'b0, 4'hB, 8'h00, 1'b1, 8'h00};
        vecs[4]  = '{1'b1, 4'hB, 8'h5A, 1'b1, 8'h00};
        vecs[5]  = '{1'b0, 4'hB, 8'h00, 1'b1, 8'h5A};
        vecs[6]  = '{1'b1, 4'h9, 8'hC3, 1'b1, 8'h00};
        vecs[7]  = '{1'b0, 4'h9, 8'h00, 1'b1, 8'hC3};
        vecs[8]  = '{1'b1, 4'h4, 8'h11, 1'b0, 8'h00};
        vecs[9]  = '{1'b0, 4'h4, 8'h00, 1'b0, 8'h00};
        vecs[10] = '{1'b0, 4'h8, 8'h00, 1'b1, 8'h00};
        vecs[11] = '{1'b0, 4'hB, 8'h00, 1'b1, 8'h5A};

        #1;
        check1("rst_ack", ack, 1'b0);
        check1("rst_oe", oe, 1'b0);
        check1("rst_err", err, 1'b0);
        @(negedge c);
        r = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) access(vecs[i]);

        // Miss: writes to an unmapped address must be ignored for the whole strobe.
        req = 1'b1; wr = 1'b1; adr = 4'h3; drv = 8'hFF; drv_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check1("miss_ack", ack, 1'b0);
            check1("miss_oe", oe, 1'b0);
        end
        req = 1'b0; wr = 1'b0; drv_en = 1'b0;
        tick();
        access('{1'b0, 4'hB, 8'h00, 1'b1, 8'h00});

        // Write aborted during ACT: no ack, no commit.
        req = 1'b1; wr = 1'b1; adr = 4'h8; drv = 8'h3C; drv_en = 1'b1;
        tick();
        check1("abw_ack_act", ack, 1'b0);
        req = 1'b0; wr = 1'b0; drv_en = 1'b0;
        tick();
        check1("abw_ack", ack, 1'b0);
        check1("abw_oe", oe, 1'b0);
        tick();
        access('{1'b0, 4'h8, 8'h00, 1'b1, 8'h00});

        // Read aborted during ACT: drive drops on the abort edge.
        req = 1'b1; adr = 4'hA;
        tick();
        check1("abr_oe_act", oe, 1'b1);
        req = 1'b0;
        tick();
        check1("abr_oe", oe, 1'b0);
        check1("abr_ack", ack, 1'b0);
        tick();

        // Reset in the middle of a read HOLD releases the bus immediately.
        access('{1'b1, 4'h8, 8'h77, 1'b1, 8'h00});
        req = 1'b1; adr = 4'h8;
        tick();
        tick();
        check1("rh_ack", ack, 1'b1);
        check8("rh_data", data, 8'h77);
        #2 r = 1'b1;
        #1;
        check1("rh_rst_ack", ack, 1'b0);
        check1("rh_rst_oe", oe, 1'b0);
        req = 1'b0;
        @(negedge c);
        r = 1'b0;
        tick();
        access('{1'b0, 4'h8, 8'h00, 1'b1, 8'h00});
        access('{1'b0, 4'hA, 8'h00, 1'b1, 8'h00});

        for (int i = 4; i < 12; i++) access(vecs[i]);

        // wr/adr changes after ACT are ignored: read of B continues, reg 8 untouched.
        req = 1'b1; wr = 1'b0; adr = 4'hB;
        tick();
        wr = 1'b1; adr = 4'h8;
        tick();
        check1("lat_ack", ack, 1'b1);
        check1("lat_oe", oe, 1'b1);
        check8("lat_data", data, 8'h5A);
        req = 1'b0; wr = 1'b0;
        tick();
        tick();
        access('{1'b0, 4'h8, 8'h00, 1'b1, 8'h00});

        // Long read strobe held for 25 cycles after ACT.
        req = 1'b1; adr = 4'hB;
        tick();
        for (int i = 1; i <= 25; i++) begin
            logic ea;
            logic ee;
`ifdef TGT_TIMEOUT_EN
            ea = (i <= 16);
            ee = (i == 17);
`else
            ea = 1'b1;
            ee = 1'b0;
`endif
            tick();
            check1("long_ack", ack, ea);
            check1("long_oe", oe, ea);
            check1("long_err", err, ee);
        end
        req = 1'b0;
        tick();
        check1("long_rel_ack", ack, 1'b0);
        check1("long_rel_oe", oe, 1'b0);
        check1("long_rel_err", err, 1'b0);
        tick();
        access('{1'b0, 4'hB, 8'h00, 1'b1, 8'h5A});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
